// File: rtl/fios_mm_sequencer_if.sv
// Host / multiplier-facing signal bundle of the FIOS operand/result sequencer.
// The slave modport is the sequencer; the master modport is the host plus multiplier side.
interface fios_mm_sequencer_if #(
  parameter int WORD_WIDTH = 17,
  parameter int PE_NB      = 8
);
  // Handshake: a load word transfers on a rising edge where load_valid_i && load_ready_o;
  // valid must not depend on ready. The RES stream is valid-only, without backpressure.
  logic                        load_valid_i;
  logic                        load_ready_o;
  logic [1:0]                  load_sel_i;
  logic [WORD_WIDTH-1:0]       load_data_i;
  logic                        go_i;
  logic                        busy_o;
  logic                        mm_start_o;
  logic [PE_NB*WORD_WIDTH-1:0] mm_a_o;
  logic                        mm_a_shift_i;
  logic                        mm_b_fetch_i;
  logic                        mm_p_fetch_i;
  logic [WORD_WIDTH-1:0]       mm_b_o;
  logic [WORD_WIDTH-1:0]       mm_p_o;
  logic                        mm_res_push_i;
  logic [WORD_WIDTH-1:0]       mm_res_i;
  logic                        mm_done_i;
  logic                        res_valid_o;
  logic [WORD_WIDTH-1:0]       res_data_o;
  logic                        res_last_o;
  logic                        done_o;
  logic                        err_o;
  logic [1:0]                  dbg_state_o;

  modport slave (
    input  load_valid_i, load_sel_i, load_data_i, go_i, mm_a_shift_i, mm_b_fetch_i,
           mm_p_fetch_i, mm_res_push_i, mm_res_i, mm_done_i,
    output load_ready_o, busy_o, mm_start_o, mm_a_o, mm_b_o, mm_p_o, res_valid_o,
           res_data_o, res_last_o, done_o, err_o, dbg_state_o
  );

  modport master (
    output load_valid_i, load_sel_i, load_data_i, go_i, mm_a_shift_i, mm_b_fetch_i,
           mm_p_fetch_i, mm_res_push_i, mm_res_i, mm_done_i,
    input  load_ready_o, busy_o, mm_start_o, mm_a_o, mm_b_o, mm_p_o, res_valid_o,
           res_data_o, res_last_o, done_o, err_o, dbg_state_o
  );
endinterface

// File: rtl/fios_mm_sequencer.sv
// Operand/result sequencer for one FIOS Montgomery multiplier: buffers a/b/p, serves the
// multiplier's window and word fetches, forwards RES words and reports done/error/timeout.
module fios_mm_sequencer #(
  parameter int s          = 8,
  parameter int WORD_WIDTH = 17,
  parameter int PE_NB      = 8,
  parameter int TIMEOUT    = 4096
) (
  input logic                clock_i,
  input logic                reset_n_i,
  fios_mm_sequencer_if.slave bus
);
  localparam int PTR_W   = (s > 1) ? $clog2(s) : 1;
  localparam int CNT_W   = $clog2(s + 1);
  localparam int WIN_W   = $clog2(s / PE_NB + 2);
  localparam int WD_W    = $clog2(TIMEOUT);
  localparam int WIN_MAX = (s + PE_NB - 1) / PE_NB;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wptr_q [3];
  logic [PTR_W-1:0]        wptr_d [3];
  logic [2:0]              complete_q, complete_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [PTR_W-1:0]        b_ptr_q, b_ptr_d, p_ptr_q, p_ptr_d;
  logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    start_q, start_d, ready_q, ready_d, busy_q, busy_d;
  logic                    res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [WORD_WIDTH-1:0]   res_data_q, res_data_d;
  logic [WORD_WIDTH-1:0]   mem_q [3][s];
  logic [PE_NB*WORD_WIDTH-1:0] a_win;
  logic                    load_fire, mem_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(s - 1)) ? '0 : p + 1'b1;
  endfunction

  assign load_fire = bus.load_valid_i && ready_q && (state_q == IDLE);
  assign mem_we    = load_fire && (bus.load_sel_i != 2'd3);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    complete_d  = complete_q;
    win_d       = win_q;
    b_ptr_d     = b_ptr_q;
    p_ptr_d     = p_ptr_q;
    res_cnt_d   = res_cnt_q;
    wd_d        = wd_q;
    res_data_d  = res_data_q;
    start_d     = 1'b0;
    res_valid_d = 1'b0;
    res_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          if (bus.load_sel_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            wptr_d[bus.load_sel_i] = ptr_inc(wptr_q[bus.load_sel_i]);
            if (wptr_q[bus.load_sel_i] == PTR_W'(s - 1)) complete_d[bus.load_sel_i] = 1'b1;
          end
        end
        // go looks at the flags as they were before any same-cycle write
        if (bus.go_i) begin
          if (&complete_q) begin
            state_d = START;
            start_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        win_d     = '0;
        b_ptr_d   = '0;
        p_ptr_d   = '0;
        res_cnt_d = '0;
        wd_d      = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (bus.mm_a_shift_i && (win_q != WIN_W'(WIN_MAX))) win_d = win_q + 1'b1;
        if (bus.mm_b_fetch_i) b_ptr_d = ptr_inc(b_ptr_q);
        if (bus.mm_p_fetch_i) p_ptr_d = ptr_inc(p_ptr_q);
        if (bus.mm_res_push_i) begin
          if (res_cnt_q != CNT_W'(s)) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.mm_res_i;
            res_last_d  = (res_cnt_q == CNT_W'(s - 1));
            res_cnt_d   = res_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // a done in the final watchdog cycle still completes normally
        if (bus.mm_done_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (res_cnt_d != CNT_W'(s)) err_d = 1'b1;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      wptr_q      <= '{default: '0};
      complete_q  <= '0;
      win_q       <= '0;
      b_ptr_q     <= '0;
      p_ptr_q     <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      start_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      complete_q  <= complete_d;
      win_q       <= win_d;
      b_ptr_q     <= b_ptr_d;
      p_ptr_q     <= p_ptr_d;
      res_cnt_q   <= res_cnt_d;
      wd_q        <= wd_d;
      start_q     <= start_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Operand storage is plain RAM: contents survive reset, only pointers and flags clear.
  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[bus.load_sel_i][wptr_q[bus.load_sel_i]] <= bus.load_data_i;
  end

  always_comb begin
    a_win = '0;
    if (state_q == RUN) begin
      for (int j = 0; j < PE_NB; j++) begin
        if (int'(win_q) * PE_NB + j < s)
          a_win[j*WORD_WIDTH +: WORD_WIDTH] = mem_q[0][PTR_W'(int'(win_q) * PE_NB + j)];
      end
    end
  end

  assign bus.mm_a_o       = a_win;
  assign bus.mm_b_o       = (state_q == RUN) ? mem_q[1][b_ptr_q] : '0;
  assign bus.mm_p_o       = (state_q == RUN) ? mem_q[2][p_ptr_q] : '0;
  assign bus.load_ready_o = ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.mm_start_o   = start_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_data_o   = res_data_q;
  assign bus.res_last_o   = res_last_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_fios_mm_sequencer.sv
// Bench for fios_mm_sequencer: scenario tasks with randomized multiplier activity checked
// against a word-count based model of the operand buffers and the RES stream.
module tb_fios_mm_sequencer;
  localparam int S      = 8;
  localparam int WW     = 17;
  localparam int PE     = 8;
  localparam int TO     = 16;
  localparam int WINMAX = (S + PE - 1) / PE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [WW-1:0] mem_m [3][S];
  int            wcnt_m [3];
  logic [WW-1:0] exp_q [$];

  always #5 clk = ~clk;

  fios_mm_sequencer_if #(.WORD_WIDTH(WW), .PE_NB(PE)) bus ();

  fios_mm_sequencer #(.s(S), .WORD_WIDTH(WW), .PE_NB(PE), .TIMEOUT(TO)) dut (
    .clock_i  (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load_valid_i  = 1'b0;
    bus.load_sel_i    = 2'd0;
    bus.load_data_i   = '0;
    bus.go_i          = 1'b0;
    bus.mm_a_shift_i  = 1'b0;
    bus.mm_b_fetch_i  = 1'b0;
    bus.mm_p_fetch_i  = 1'b0;
    bus.mm_res_push_i = 1'b0;
    bus.mm_res_i      = '0;
    bus.mm_done_i     = 1'b0;
  endtask

  // Operand k of a sequence of writes lands in word k mod S; S writes make it complete.
  function automatic void model_write(input int sel, input logic [WW-1:0] d);
    if (sel < 3) begin
      mem_m[sel][wcnt_m[sel] % S] = d;
      wcnt_m[sel]++;
    end
  endfunction

  function automatic bit all_complete();
    return (wcnt_m[0] >= S) && (wcnt_m[1] >= S) && (wcnt_m[2] >= S);
  endfunction

  task automatic load_word(input int sel, input logic [WW-1:0] d, input bit go);
    bit pre_ok, exp_err;
    pre_ok = all_complete();
    checks++;
    if (bus.load_ready_o !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b want 1", bus.load_ready_o);
    end
    bus.load_valid_i = 1'b1;
    bus.load_sel_i   = 2'(sel);
    bus.load_data_i  = d;
    bus.go_i         = go;
    step();
    clear_inputs();
    model_write(sel, d);
    exp_err = (sel == 3) || (go && !pre_ok);
    checks++;
    if (bus.err_o !== exp_err) begin
      errors++; $display("FAIL load_err sel=%0d go=%0b: got %b want %b", sel, go, bus.err_o, exp_err);
    end
    checks++;
    if (bus.mm_start_o !== (go && pre_ok)) begin
      errors++; $display("FAIL load_start: got %b want %b", bus.mm_start_o, go && pre_ok);
    end
  endtask

  task automatic load_operand(input int sel, input int base);
    for (int i = 0; i < S; i++) load_word(sel, WW'(base + i), 1'b0);
  endtask

  // One full operation: go, n_cyc RUN cycles (done on the last), n_push RES pushes.
  task automatic run_op(input int n_cyc, input int n_push, input bit all_b, input bit seq_data);
    int shifts, bf, pf, pushed, acc, w, idx;
    bit psh, ov, last_c, sh_now, bf_now, pf_now, exp_err;
    logic [WW-1:0] d, exp_w, got_w;
    shifts = 0; bf = 0; pf = 0; pushed = 0; acc = 0;
    exp_q.delete();
    bus.go_i = 1'b1;
    step();
    bus.go_i = 1'b0;
    checks++;
    if (bus.mm_start_o !== 1'b1) begin
      errors++; $display("FAIL start_pulse: got %b want 1", bus.mm_start_o);
    end
    checks++;
    if (bus.busy_o !== 1'b1 || bus.load_ready_o !== 1'b0) begin
      errors++; $display("FAIL start_state: busy=%b ready=%b want 1/0", bus.busy_o, bus.load_ready_o);
    end
    step();
    checks++;
    if (bus.mm_start_o !== 1'b0) begin
      errors++; $display("FAIL start_width: got %b want 0", bus.mm_start_o);
    end
    for (int c = 0; c < n_cyc; c++) begin
      w = (shifts < WINMAX) ? shifts : WINMAX;
      for (int j = 0; j < PE; j++) begin
        idx = w * PE + j;
        exp_w = '0;
        if (idx < S) exp_w = mem_m[0][idx];
        got_w = bus.mm_a_o[j*WW +: WW];
        checks++;
        if (got_w !== exp_w) begin
          errors++; $display("FAIL a_window win=%0d j=%0d: got %h want %h", w, j, got_w, exp_w);
        end
      end
      checks++;
      if (bus.mm_b_o !== mem_m[1][bf % S]) begin
        errors++; $display("FAIL b_word fetch=%0d: got %h want %h", bf, bus.mm_b_o, mem_m[1][bf % S]);
      end
      checks++;
      if (bus.mm_p_o !== mem_m[2][pf % S]) begin
        errors++; $display("FAIL p_word fetch=%0d: got %h want %h", pf, bus.mm_p_o, mem_m[2][pf % S]);
      end
      last_c = (c == n_cyc - 1);
      psh    = (pushed < n_push) && (($urandom_range(0, 1) == 1) || (n_push - pushed >= n_cyc - c));
      d      = seq_data ? WW'(pushed + 1) : WW'($urandom);
      sh_now = ($urandom_range(0, 3) == 0);
      bf_now = all_b || ($urandom_range(0, 1) == 1);
      pf_now = ($urandom_range(0, 1) == 1);
      bus.mm_a_shift_i  = sh_now;
      bus.mm_b_fetch_i  = bf_now;
      bus.mm_p_fetch_i  = pf_now;
      bus.mm_res_push_i = psh;
      bus.mm_res_i      = d;
      bus.mm_done_i     = last_c;
      ov = 1'b0;
      if (psh) begin
        pushed++;
        if (acc < S) begin
          acc++;
          exp_q.push_back(d);
        end else begin
          ov = 1'b1;
        end
      end
      step();
      clear_inputs();
      shifts += int'(sh_now);
      bf     += int'(bf_now);
      pf     += int'(pf_now);
      if (psh && !ov) begin
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== exp_q[0] || bus.res_last_o !== (acc == S)) begin
          errors++;
          $display("FAIL res_word #%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   acc, bus.res_valid_o, bus.res_data_o, bus.res_last_o, exp_q[0], acc == S);
        end
        void'(exp_q.pop_front());
      end else begin
        checks++;
        if (bus.res_valid_o !== 1'b0) begin
          errors++; $display("FAIL res_idle: got valid %b want 0", bus.res_valid_o);
        end
      end
      exp_err = ov || (last_c && acc != S);
      checks++;
      if (bus.err_o !== exp_err) begin
        errors++; $display("FAIL run_err cycle=%0d: got %b want %b", c, bus.err_o, exp_err);
      end
      checks++;
      if (bus.done_o !== last_c) begin
        errors++; $display("FAIL run_done cycle=%0d: got %b want %b", c, bus.done_o, last_c);
      end
      checks++;
      if (bus.busy_o !== 1'b1) begin
        errors++; $display("FAIL run_busy cycle=%0d: got %b want 1", c, bus.busy_o);
      end
    end
    step();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b done=%b err=%b ready=%b want 0/0/0/1",
               bus.busy_o, bus.done_o, bus.err_o, bus.load_ready_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.load_ready_o, bus.busy_o, bus.mm_start_o, bus.res_valid_o, bus.res_last_o,
         bus.done_o, bus.err_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got ready=%b busy=%b start=%b want all 0",
                         bus.load_ready_o, bus.busy_o, bus.mm_start_o);
    end
    checks++;
    if (bus.mm_a_o !== '0 || bus.mm_b_o !== '0 || bus.mm_p_o !== '0 || bus.res_data_o !== '0) begin
      errors++; $display("FAIL reset_data: got a=%h b=%h p=%h res=%h want 0",
                         bus.mm_a_o, bus.mm_b_o, bus.mm_p_o, bus.res_data_o);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.load_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", bus.load_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_go_incomplete();
    load_operand(0, 0);
    load_operand(1, 10);
    bus.go_i = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mm_start_o !== 1'b0) begin
      errors++; $display("FAIL go_incomplete: err=%b busy=%b start=%b want 1/0/0",
                         bus.err_o, bus.busy_o, bus.mm_start_o);
    end
    step();
    checks++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL go_incomplete_after: err=%b busy=%b want 0/0", bus.err_o, bus.busy_o);
    end
  endtask

  task automatic test_load_go_same_cycle();
    for (int i = 0; i < S - 1; i++) load_word(2, WW'(20 + i), 1'b0);
    load_word(2, WW'(20 + S - 1), 1'b1);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL load_go_busy: got %b want 0", bus.busy_o);
    end
  endtask

  task automatic test_illegal_sel();
    for (int i = 0; i < S; i++) begin
      if (i == S / 2) load_word(3, WW'(999), 1'b0);
      load_word(0, WW'(100 + i), 1'b0);
    end
    run_op(10, S, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n_reload, sel, cnt, n_cyc, n_push;
    for (int it = 0; it < 20; it++) begin
      n_reload = $urandom_range(0, 2);
      for (int r = 0; r < n_reload; r++) begin
        sel = $urandom_range(0, 3);
        cnt = $urandom_range(1, S);
        for (int k = 0; k < cnt; k++) load_word(sel, WW'($urandom), 1'b0);
      end
      n_cyc  = $urandom_range(1, 14);
      n_push = ($urandom_range(0, 1) == 1 && n_cyc >= S) ? S : $urandom_range(0, n_cyc);
      run_op(n_cyc, n_push, 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout();
    bit exp_err, exp_busy;
    bus.go_i = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.mm_start_o !== 1'b1) begin
      errors++; $display("FAIL timeout_start: got %b want 1", bus.mm_start_o);
    end
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      exp_err  = (k == TO + 1);
      exp_busy = (k <= TO);
      checks++;
      if (bus.err_o !== exp_err || bus.busy_o !== exp_busy || bus.done_o !== 1'b0) begin
        errors++; $display("FAIL timeout k=%0d: err=%b busy=%b done=%b want %b/%b/0",
                           k, bus.err_o, bus.busy_o, bus.done_o, exp_err, exp_busy);
      end
    end
    step();
    checks++;
    if (bus.err_o !== 1'b0 || bus.load_ready_o !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: err=%b ready=%b want 0/1", bus.err_o, bus.load_ready_o);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.go_i = 1'b1;
    step();
    clear_inputs();
    step();
    bus.mm_res_push_i = 1'b1;
    bus.mm_res_i      = WW'($urandom);
    bus.mm_b_fetch_i  = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.res_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: valid=%b busy=%b want 1/1", bus.res_valid_o, bus.busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.load_ready_o, bus.busy_o, bus.mm_start_o, bus.res_valid_o, bus.res_last_o,
         bus.done_o, bus.err_o} !== 7'b0) begin
      errors++; $display("FAIL midrun_reset_ctrl: busy=%b valid=%b err=%b want 0",
                         bus.busy_o, bus.res_valid_o, bus.err_o);
    end
    checks++;
    if (bus.mm_a_o !== '0 || bus.mm_b_o !== '0 || bus.mm_p_o !== '0 || bus.res_data_o !== '0) begin
      errors++; $display("FAIL midrun_reset_data: a=%h b=%h p=%h res=%h want 0",
                         bus.mm_a_o, bus.mm_b_o, bus.mm_p_o, bus.res_data_o);
    end
    step();
    checks++;
    if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++; $display("FAIL midrun_quiet: done=%b err=%b want 0/0", bus.done_o, bus.err_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) wcnt_m[i] = 0;
    step();
    bus.go_i = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.err_o !== 1'b1 || bus.mm_start_o !== 1'b0) begin
      errors++; $display("FAIL flags_cleared: err=%b start=%b want 1/0", bus.err_o, bus.mm_start_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) wcnt_m[i] = 0;
    test_reset();
    test_go_incomplete();
    test_load_go_same_cycle();
    run_op(10, S, 1'b1, 1'b1);
    run_op(9, 6, 1'b0, 1'b1);
    run_op(12, S, 1'b0, 1'b0);
    test_illegal_sel();
    run_op(12, S + 2, 1'b0, 1'b0);
    test_random();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_watchdog: run did not end within time budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
